bip_prog_loader: RTL

- UART-fed program loader directly upstream of the BIP core.
- Consumes bytes from the UART receiver (rx done strobe plus data byte) and assembles little-endian instruction words.
- Writes the words into BIP program memory, verifies an XOR checksum, then releases the BIP from reset.
- Mirror of the result-transmit path: host downloads the program here and reads ACC back via uart_tx after halt.

---
 rtl/bip_pkg.sv | 24 ++
 rtl/loader_timeout_cnt.sv | 47 ++++
 rtl/bip_prog_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// bip_pkg: shared definitions for the BIP program loader.
//   - state_e    : loader FSM state encoding
//   - ERR_*      : latched error codes reported on o_err
//   - SYNC_BYTE  : default frame start byte
package bip_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StDataLo,
        StDataHi,
        StChk,
        StRun
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_timeout_cnt.sv
// loader_timeout_cnt: loadable up-counter with clear/enable and terminal-count flag.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_ld, i_ld_val   load counter with i_ld_val (highest priority)
//   i_clr            clear counter to zero
//   i_en             count enable; o_tc only asserts while enabled
//   i_term           terminal count value
//   o_tc             counter equals i_term while enabled
module loader_timeout_cnt #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_ld) begin
            cnt_d = i_ld_val;
        end else if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag does not depend on i_clr, so a byte landing on the terminal cycle
    // still sees the timeout.
    assign o_tc = i_en && (cnt_q == i_term);

endmodule

// File: rtl/bip_prog_loader.sv
// bip_prog_loader: UART-fed program loader in front of the BIP core.
// Frame: SYNC, LEN_LO, LEN_HI, LEN x (lo, hi), CHK where CHK is the XOR of every byte
// between SYNC and CHK. Words are written to program memory, the checksum is verified,
// then the CPU is released from reset.
// Ports:
//   i_clk, i_reset         clock, asynchronous active-low reset
//   i_rx_done, i_rx_data   received byte strobe and data
//   i_halt                 BIP halt flag (enables reload while running)
//   o_mem_we/addr/data     program memory write port, one-cycle write pulse
//   o_cpu_rst              active-high reset to the BIP
//   o_busy                 frame in progress
//   o_load_done            one-cycle pulse after a good checksum
//   o_err                  latched error code (none/checksum/length/timeout)
module bip_prog_loader
    import bip_pkg::*;
#(
    parameter int unsigned     NBITS_I = 16,
    parameter int unsigned     NBITS_A = 11,
    parameter int unsigned     DBIT    = 8,
    parameter logic [DBIT-1:0] SYNC    = SYNC_BYTE,
    parameter int unsigned     TIMEOUT = 200000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [DBIT-1:0]    i_rx_data,
    input  logic               i_halt,
    output logic               o_mem_we,
    output logic [NBITS_A-1:0] o_mem_addr,
    output logic [NBITS_I-1:0] o_mem_data,
    output logic               o_cpu_rst,
    output logic               o_busy,
    output logic               o_load_done,
    output logic [1:0]         o_err
);

    localparam int unsigned LW = 2 * DBIT;
    // One extra bit so a full 2^NBITS_A word program is representable.
    localparam int unsigned IW = NBITS_A + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [LW:0] MAX_LEN = (LW + 1)'(2 ** NBITS_A);

    state_e state_q, state_d;

    logic [LW-1:0]      len_q;
    logic [DBIT-1:0]    chk_q;
    logic [DBIT-1:0]    lo_q;
    logic [IW-1:0]      idx_q;
    logic               mem_we_q;
    logic [NBITS_A-1:0] mem_addr_q;
    logic [NBITS_I-1:0] mem_data_q;
    logic               load_done_q;
    logic [1:0]         err_q;

    logic          busy;
    logic          tmo;
    logic          rx_sync;
    logic          restart;
    logic [LW:0]   len_full;
    logic          len_too_long;
    logic          len_zero;
    logic [IW-1:0] idx_inc;
    logic          last_word;

    assign rx_sync = i_rx_done && (i_rx_data == SYNC);
    // SYNC is honoured when idle, or when running with the CPU halted (reload).
    assign restart = rx_sync && ((state_q == StIdle) || ((state_q == StRun) && i_halt));

    assign len_full     = {1'b0, i_rx_data, len_q[DBIT-1:0]};
    assign len_too_long = len_full > MAX_LEN;
    assign len_zero     = (len_full == '0);
    assign idx_inc      = idx_q + 1'b1;
    assign last_word    = (LW'(idx_inc) == len_q);

    loader_timeout_cnt #(
        .WIDTH(TW)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ld    (1'b0),
        .i_ld_val('0),
        .i_clr   (i_rx_done | ~busy),
        .i_en    (busy),
        .i_term  (TW'(TIMEOUT - 1)),
        .o_tc    (tmo)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; timeout takes priority over a same-cycle byte.
    always_comb begin
        state_d = state_q;
        if (tmo) begin
            state_d = StIdle;
        end else if (restart) begin
            state_d = StLenLo;
        end else if (i_rx_done) begin
            case (state_q)
                StLenLo:  state_d = StLenHi;
                StLenHi: begin
                    if (len_too_long) begin
                        state_d = StIdle;
                    end else if (len_zero) begin
                        state_d = StChk;
                    end else begin
                        state_d = StDataLo;
                    end
                end
                StDataLo: state_d = StDataHi;
                StDataHi: state_d = last_word ? StChk : StDataLo;
                StChk:    state_d = (i_rx_data == chk_q) ? StRun : StIdle;
                default:  state_d = state_q;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        busy      = 1'b0;
        o_cpu_rst = 1'b1;
        case (state_q)
            StLenLo, StLenHi, StDataLo, StDataHi, StChk: busy = 1'b1;
            StRun:                                       o_cpu_rst = 1'b0;
            default:                                     busy = 1'b0;
        endcase
    end

    assign o_busy = busy;

    // Datapath: length, checksum, word index, write port and status flags.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            len_q       <= '0;
            chk_q       <= '0;
            lo_q        <= '0;
            idx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            load_done_q <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            if (tmo) begin
                err_q <= ERR_TMO;
            end else if (restart) begin
                err_q <= ERR_NONE;
                chk_q <= '0;
                idx_q <= '0;
            end else if (i_rx_done) begin
                case (state_q)
                    StLenLo: begin
                        len_q[DBIT-1:0] <= i_rx_data;
                        chk_q           <= chk_q ^ i_rx_data;
                    end
                    StLenHi: begin
                        len_q[LW-1:DBIT] <= i_rx_data;
                        chk_q            <= chk_q ^ i_rx_data;
                        if (len_too_long) begin
                            err_q <= ERR_LEN;
                        end
                    end
                    StDataLo: begin
                        lo_q  <= i_rx_data;
                        chk_q <= chk_q ^ i_rx_data;
                    end
                    StDataHi: begin
                        chk_q      <= chk_q ^ i_rx_data;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= idx_q[NBITS_A-1:0];
                        mem_data_q <= NBITS_I'({i_rx_data, lo_q});
                        idx_q      <= idx_inc;
                    end
                    StChk: begin
                        if (i_rx_data == chk_q) begin
                            load_done_q <= 1'b1;
                        end else begin
                            err_q <= ERR_CHK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;
    assign o_load_done = load_done_q;
    assign o_err       = err_q;

endmodule
